// File: rtl/regfile_pkg.sv
// Shared sizing defaults and address/data types for the integer register file.
// Register 31 is the hardwired zero register (XZR).
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_NUM_REGS   = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int ZERO_REG           = 31;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/register_row.sv
// One storage row of the register file: a WIDTH-bit register that loads `in`
// when write_enable is high and holds otherwise; async reset clears it.
module register_row
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             write_enable,
    input  logic             reset,
    input  logic             clk
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic bit_d;
        logic bit_q;

        always_comb begin
            bit_d = bit_q;
            if (write_enable) begin
                bit_d = in[b];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                bit_q <= 1'b0;
            end else begin
                bit_q <= bit_d;
            end
        end

        assign out[b] = bit_q;
    end

endmodule

// File: rtl/regfile.sv
// Architectural integer register file: NUM_REGS-1 storage rows plus a hardwired
// zero register at the top index, two combinational read ports, one write port.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    logic [NUM_REGS-2:0]   row_we;
    logic [DATA_WIDTH-1:0] row_val [NUM_REGS];
    logic                  write_live;
    logic                  hit1;
    logic                  hit2;

    // A write only counts when it targets a real row and reset is low.
    assign write_live = write_enable && !reset && (write_reg != ZERO_ADDR);

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_row
        assign row_we[i] = write_live && (write_reg == ADDR_WIDTH'(i));

        register_row #(
            .WIDTH(DATA_WIDTH)
        ) u_row (
            .out         (row_val[i]),
            .in          (write_data),
            .write_enable(row_we[i]),
            .reset       (reset),
            .clk         (clk)
        );
    end

    assign row_val[NUM_REGS-1] = '0;

    // Same-cycle forwarding exists only in the BYPASS build.
    assign hit1 = (BYPASS != 0) && write_live && (read_reg1 == write_reg);
    assign hit2 = (BYPASS != 0) && write_live && (read_reg2 == write_reg);

    assign read_data1 = hit1 ? write_data : row_val[read_reg1];
    assign read_data2 = hit2 ? write_data : row_val[read_reg2];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: one BYPASS=0 and one BYPASS=1 instance share
// the same stimulus and are checked against an array model of the register file.
module tb_regfile;
   import regfile_pkg::*;

   logic      clk = 1'b0;
   logic      reset;
   reg_addr_t read_reg1;
   reg_addr_t read_reg2;
   reg_addr_t write_reg;
   reg_data_t write_data;
   logic      write_enable;
   reg_data_t rd1Plain;
   reg_data_t rd2Plain;
   reg_data_t rd1Fwd;
   reg_data_t rd2Fwd;

   int checkCount = 0;
   int failCount  = 0;

   reg_data_t model [32];

   typedef struct {
      logic      we;
      reg_addr_t wr;
      reg_data_t wd;
      reg_addr_t r1;
      reg_addr_t r2;
      reg_data_t e1;
      reg_data_t e2;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   regfile #(.BYPASS(0)) dutPlain (
      .clk         (clk),
      .reset       (reset),
      .read_reg1   (read_reg1),
      .read_reg2   (read_reg2),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .write_enable(write_enable),
      .read_data1  (rd1Plain),
      .read_data2  (rd2Plain)
   );

   regfile #(.BYPASS(1)) dutFwd (
      .clk         (clk),
      .reset       (reset),
      .read_reg1   (read_reg1),
      .read_reg2   (read_reg2),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .write_enable(write_enable),
      .read_data1  (rd1Fwd),
      .read_data2  (rd2Fwd)
   );

   // Single comparison point; every check in the bench goes through here.
   task checkOutput(input string name, input reg_data_t act, input reg_data_t exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task modelReset();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Stored contents as seen before the coming edge.
   function automatic reg_data_t expStored(input reg_addr_t r);
      if (reset) return '0;
      return model[r];
   endfunction

   // Forwarded view: a live write to the same non-zero register wins.
   function automatic reg_data_t expForward(input reg_addr_t r);
      if (!reset && write_enable && write_reg != reg_addr_t'(ZERO_REG) && r == write_reg)
         return write_data;
      return expStored(r);
   endfunction

   task applyStimulus(input logic we, input reg_addr_t wr, input reg_data_t wd,
                      input reg_addr_t r1, input reg_addr_t r2);
      write_enable = we;
      write_reg    = wr;
      write_data   = wd;
      read_reg1    = r1;
      read_reg2    = r2;
      #1;
   endtask

   // Advance one rising edge and commit the sampled write into the model.
   task clockEdge();
      @(posedge clk);
      if (!reset && write_enable && write_reg != reg_addr_t'(ZERO_REG))
         model[write_reg] = write_data;
      #1;
   endtask

   task checkPorts(input string name);
      checkOutput($sformatf("%s_p1_plain[%0d]", name, read_reg1), rd1Plain, expStored(read_reg1));
      checkOutput($sformatf("%s_p2_plain[%0d]", name, read_reg2), rd2Plain, expStored(read_reg2));
      checkOutput($sformatf("%s_p1_fwd[%0d]", name, read_reg1), rd1Fwd, expForward(read_reg1));
      checkOutput($sformatf("%s_p2_fwd[%0d]", name, read_reg2), rd2Fwd, expForward(read_reg2));
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd1,  64'h11,                  5'd1,  5'd0,  64'h11,                  64'h0};
      vecs[1] = '{1'b1, 5'd2,  64'h22,                  5'd1,  5'd2,  64'h11,                  64'h22};
      vecs[2] = '{1'b0, 5'd1,  64'h99,                  5'd1,  5'd2,  64'h11,                  64'h22};
      vecs[3] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd1,  64'h0,                   64'h11};
      vecs[4] = '{1'b1, 5'd1,  64'h33,                  5'd1,  5'd2,  64'h33,                  64'h22};
      vecs[5] = '{1'b1, 5'd0,  64'h8000_0000_0000_0001, 5'd0,  5'd30, 64'h8000_0000_0000_0001, 64'h0};
      vecs[6] = '{1'b1, 5'd30, 64'h5A5A_5A5A_A5A5_A5A5, 5'd30, 5'd0,  64'h5A5A_5A5A_A5A5_A5A5, 64'h8000_0000_0000_0001};
      vecs[7] = '{1'b1, 5'd2,  64'h44,                  5'd2,  5'd2,  64'h44,                  64'h44};

      // Reset state: every address reads zero on both ports.
      reset = 1'b1;
      modelReset();
      applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0);
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 5'd0, '0, reg_addr_t'(a), reg_addr_t'(31 - a));
         checkOutput($sformatf("reset_p1[%0d]", a), rd1Plain, 64'h0);
         checkOutput($sformatf("reset_p2[%0d]", a), rd2Fwd, 64'h0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Fill X0..X30 then read symmetric pairs.
      for (int i = 0; i < 31; i++) begin
         applyStimulus(1'b1, reg_addr_t'(i), 64'h1000 + 64'(i), reg_addr_t'(i), reg_addr_t'(30 - i));
         clockEdge();
      end
      for (int i = 0; i < 31; i++) begin
         applyStimulus(1'b0, 5'd0, '0, reg_addr_t'(i), reg_addr_t'(30 - i));
         checkOutput($sformatf("fill_p1[%0d]", i), rd1Plain, 64'h1000 + 64'(i));
         checkOutput($sformatf("fill_p2[%0d]", 30 - i), rd2Fwd, 64'h1000 + 64'(30 - i));
      end
      applyStimulus(1'b0, 5'd0, '0, 5'd31, 5'd31);
      checkOutput("fill_x31_plain", rd1Plain, 64'h0);
      checkOutput("fill_x31_fwd", rd2Fwd, 64'h0);

      // Writing XZR must leave it zero and disturb nothing else.
      applyStimulus(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd0);
      checkOutput("xzr_fwd_same_cycle", rd1Fwd, 64'h0);
      clockEdge();
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 5'd0, '0, reg_addr_t'(a), reg_addr_t'(a));
         checkOutput($sformatf("xzr_keep[%0d]", a), rd1Plain, (a == 31) ? 64'h0 : 64'h1000 + 64'(a));
         checkOutput($sformatf("xzr_keep_fwd[%0d]", a), rd2Fwd, (a == 31) ? 64'h0 : 64'h1000 + 64'(a));
      end

      // Disabled write must not land.
      applyStimulus(1'b0, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd5);
      clockEdge();
      checkOutput("gate_x5_plain", rd1Plain, 64'h1005);
      checkOutput("gate_x5_fwd", rd2Fwd, 64'h1005);

      // Read-during-write on X7.
      applyStimulus(1'b1, 5'd7, 64'hA, 5'd7, 5'd7);
      clockEdge();
      applyStimulus(1'b1, 5'd7, 64'hB, 5'd7, 5'd7);
      checkOutput("rdw_before_p1_plain", rd1Plain, 64'hA);
      checkOutput("rdw_before_p2_plain", rd2Plain, 64'hA);
      checkOutput("rdw_before_p1_fwd", rd1Fwd, 64'hB);
      checkOutput("rdw_before_p2_fwd", rd2Fwd, 64'hB);
      clockEdge();
      checkOutput("rdw_after_p1_plain", rd1Plain, 64'hB);
      checkOutput("rdw_after_p2_plain", rd2Plain, 64'hB);
      checkOutput("rdw_after_p1_fwd", rd1Fwd, 64'hB);
      checkOutput("rdw_after_p2_fwd", rd2Fwd, 64'hB);

      // Reset during a pending write: clears immediately, write lost, forwarding off.
      applyStimulus(1'b1, 5'd3, 64'h1234, 5'd3, 5'd8);
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("midrst_x3_plain", rd1Plain, 64'h0);
      checkOutput("midrst_x3_fwd", rd1Fwd, 64'h0);
      checkOutput("midrst_x8_fwd", rd2Fwd, 64'h0);
      for (int a = 0; a < 32; a++) begin
         read_reg1 = reg_addr_t'(a);
         read_reg2 = reg_addr_t'(a);
         #1;
         checkOutput($sformatf("midrst_clear[%0d]", a), rd1Plain, 64'h0);
         checkOutput($sformatf("midrst_clear_fwd[%0d]", a), rd2Fwd, 64'h0);
      end
      write_enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 5'd0, '0, 5'd3, 5'd3);
      checkOutput("midrst_after_plain", rd1Plain, 64'h0);
      checkOutput("midrst_after_fwd", rd2Fwd, 64'h0);

      // Directed vector table from a cleared file.
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].r1, vecs[v].r2);
         clockEdge();
         write_enable = 1'b0;
         #1;
         checkOutput($sformatf("vec%0d_p1_plain", v), rd1Plain, vecs[v].e1);
         checkOutput($sformatf("vec%0d_p2_plain", v), rd2Plain, vecs[v].e2);
         checkOutput($sformatf("vec%0d_p1_fwd", v), rd1Fwd, vecs[v].e1);
         checkOutput($sformatf("vec%0d_p2_fwd", v), rd2Fwd, vecs[v].e2);
      end

      // Random traffic against the array model.
      for (int n = 0; n < 400; n++) begin
         reg_addr_t wr;
         reg_addr_t r1;
         reg_addr_t r2;
         wr = reg_addr_t'($urandom_range(0, 31));
         r1 = reg_addr_t'($urandom_range(0, 31));
         r2 = reg_addr_t'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) r1 = wr;
         if ($urandom_range(0, 3) == 0) r2 = wr;
         applyStimulus(1'($urandom_range(0, 1)), wr, {$urandom, $urandom}, r1, r2);
         checkPorts("rand");
         clockEdge();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file for the single-cycle/pipelined CPU datapath. It holds 32 general registers of 64 bits each and has two asynchronous read ports and one synchronous write port. Register 31 is hardwired to zero (XZR). The file sits between instruction decode, which supplies the read addresses, and write-back, which supplies the write address and data. It is built from per-register write-enabled storage rows.

## Interface
- DATA_WIDTH, 64, bits per register
- NUM_REGS, 32, register count (power of two)
- ADDR_WIDTH, 5, log2(NUM_REGS)
- BYPASS, 0, 1 = write-to-read forwarding in the same cycle; 0 = reads return the pre-write value
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears every register
- read_reg1  input  ADDR_WIDTH  read port 1 address
- read_reg2  input  ADDR_WIDTH  read port 2 address
- write_reg  input  ADDR_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- write_enable  input  1  commit write_data to write_reg at the next rising edge
- read_data1  output  DATA_WIDTH  contents of read_reg1
- read_data2  output  DATA_WIDTH  contents of read_reg2

## Operation
- Storage: NUM_REGS-1 rows (indices 0..30). Each row holds its value when its enable is low and loads write_data when its enable is high.
- Write decode: one-hot on write_reg, gated by write_enable. At most one row is enabled per cycle.
- Row 31 has no storage. Reads of index 31 return 0. Writes to 31 are discarded with no side effect on any row.
- Reads: combinational N:1 mux per port, indexed by the read address. The two ports are fully independent and may use the same address.
- BYPASS=1: if write_enable=1, write_reg≠31 and read_regN==write_reg, then read_dataN=write_data. Otherwise read_dataN is the stored value.
- BYPASS=0: no forwarding. A read of the register being written shows the old value until after the edge.
- Reset: asserting reset forces all rows to 0 immediately, independent of clk. While reset is high, writes are ignored and every read returns 0. The BYPASS path is also suppressed during reset.

## Timing
- Reset value: every row = 0, so read_data1 = read_data2 = 0 for all addresses.
- Write latency: data is visible on the read ports in the cycle after the rising edge that sampled write_enable=1, or in the same cycle when BYPASS=1.
- Read latency: 0 cycles. Purely combinational from read_regN and the row contents.
- Back-to-back writes to the same register: the last edge wins. There are no hazards inside the block.
- Reset deasserting coincident with a rising edge: that edge's write is not required to take effect. The bench must not depend on it.
- Reset asserted mid-operation: a pending write is lost and all contents clear within the same cycle.
- Setup requirement: write_reg, write_data and write_enable stable before the rising edge. Changing them mid-cycle affects only the BYPASS output, never stored state.

## Structure
- Shared package regfile_pkg:
  - default DATA_WIDTH / NUM_REGS / ADDR_WIDTH
  - localparam ZERO_REG = 31
  - typedef reg_addr_t (logic [ADDR_WIDTH-1:0])
  - typedef reg_data_t (logic [DATA_WIDTH-1:0])
- Sub-module register_row: a DATA_WIDTH-wide write-enabled register. Ports out, in, write_enable, reset, clk. Built from per-bit enable/hold storage, replicated via generate.
- Write decoder and read muxes stay inline in regfile, using generate loops.

## Test plan
- Reset: assert reset with arbitrary prior contents → all 32 addresses read 0 on both ports within the same cycle, with no clock edge needed.
- Write/read all: write 0x0000_0000_0000_1000+i to X0..X30, then read each pair (i, 30-i) → exact values returned; X31 reads 0.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to X31 with write_enable=1 → X31 still reads 0 and X0..X30 are unchanged.
- Enable gating: write_enable=0, write_reg=5, write_data=0xDEAD_BEEF_0000_0001 → X5 keeps its prior value after the edge.
- Read-during-write: X7=0xA, then write X7=0xB with read_reg1=read_reg2=7 before the edge → BYPASS=0 shows 0xA then 0xB; BYPASS=1 shows 0xB in both cycles.
- Mid-write reset: write X3=0x1234 with reset pulsed high before the edge → X3 reads 0 after reset releases.
